tt_proj_mux_ctrl: RTL

//   Project-select and I/O multiplexer that sits directly upstream of the per-project wrappers.
//   - Counts a serial select address from the control pins.
//   - Enables exactly one project.
//   - Drives that project's packed 18-bit input word; returns the selected 24-bit output word to the pads.
//   - Non-selected projects get a zero input word, a gated-off clock and reset held asserted.

---
 rtl/tt_proj_mux_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tt_proj_mux_ctrl.sv
// ----------------------------------------------------------------------------
// tt_proj_mux_ctrl
//   Project-select and I/O multiplexer placed directly in front of the
//   per-project wrappers. Three asynchronous control pins are synchronised.
//   They drive a serial select counter and an enable handshake. The handshake
//   turns on exactly one project slot. That slot receives the pad inputs, a
//   gated clock and a delayed reset. Its outputs are routed back to the pads.
//   Every other slot sees a zero input word: clock gated off and reset held.
//
// Ports
//   clk, rst_n          pad clock; async active-low reset (also fed to projects)
//   ctrl_sel_rst_n      async pin, low clears the select counter
//   ctrl_sel_inc        async pin, rising edge increments the select counter
//   ctrl_ena            async pin, rising edge enables the counted slot,
//                       low disables it
//   ui_in, uio_in       pad inputs, forwarded to the selected slot
//   uo_out, uio_out,    outputs of the selected slot, 0 when no slot is active
//   uio_oe
//   proj_ena            one-hot slot enable
//   proj_iw             slot k word at [18k+17:18k] = {uio_in, ui_in, rst_n, clk}
//   proj_ow             slot k word at [24k+23:24k] = {uio_oe, uio_out, uo_out}
//   sel_addr            current select counter value
//   active              a valid slot is enabled
//
// Configuration
//   TT_MUX_OUT_REG_EN   when defined, the pad outputs are registered on clk.
//                       This adds one cycle from proj_ow. When undefined, the
//                       output mux is purely combinational.
// ----------------------------------------------------------------------------
module tt_proj_mux_ctrl #(
    parameter int unsigned N_PROJ   = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ctrl_sel_rst_n,
    input  logic                   ctrl_sel_inc,
    input  logic                   ctrl_ena,
    input  logic [7:0]             ui_in,
    input  logic [7:0]             uio_in,
    output logic [7:0]             uo_out,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe,
    output logic [N_PROJ-1:0]      proj_ena,
    output logic [18*N_PROJ-1:0]   proj_iw,
    input  logic [24*N_PROJ-1:0]   proj_ow,
    output logic [AW-1:0]          sel_addr,
    output logic                   active
);

    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    // Synchronisers: bit0 = s1, bit1 = s2, bit2 = history (s3).
    // The select-reset pin is level-only, so it needs no history stage.
    logic [1:0]        sel_rst_sync_q;
    logic [2:0]        inc_sync_q;
    logic [2:0]        ena_sync_q;
    logic [1:0]        sync_valid_q;
    logic              ena_armed_q, ena_armed_d;

    logic [AW-1:0]     sel_cnt_q, sel_cnt_d;
    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     cur_sel_q, cur_sel_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              active_q, active_d;
    logic [N_PROJ-1:0] proj_ena_q, proj_ena_d;

    logic              sel_rst_s2;
    logic              ena_s2;
    logic              inc_edge;
    logic              ena_edge;
    logic              cnt_in_range;

    logic              clk_en_lat;
    logic              gclk;
    logic              iw_rst;
    logic [23:0]       sel_ow;
    logic [23:0]       ow_mux;

    assign sel_rst_s2 = sel_rst_sync_q[1];
    assign ena_s2     = ena_sync_q[1];
    assign inc_edge   = inc_sync_q[1] & ~inc_sync_q[2];
    // An enable edge counts only once the pin has been seen low after reset.
    // This stops a pin held high through reset from re-enabling a slot.
    assign ena_edge   = ena_sync_q[1] & ~ena_sync_q[2] & ena_armed_q;
    assign ena_armed_d = ena_armed_q | (~ena_s2 & sync_valid_q[1]);

    assign cnt_in_range = (32'(sel_cnt_q) < N_PROJ);

    // Select counter: a held-low clear beats a simultaneous increment edge.
    always_comb begin
        sel_cnt_d = sel_cnt_q;
        if (!sel_rst_s2) begin
            sel_cnt_d = '0;
        end else if (inc_edge) begin
            sel_cnt_d = sel_cnt_q + AW'(1);
        end
    end

    // Enable FSM: IDLE -> HOLD (slot reset held) -> RUN.
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ena_edge && cnt_in_range) begin
                    state_d    = ST_HOLD;
                    cur_sel_d  = sel_cnt_q;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (!ena_s2) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (!ena_s2) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        active_d   = (state_d != ST_IDLE);
        proj_ena_d = '0;
        for (int unsigned k = 0; k < N_PROJ; k++) begin
            proj_ena_d[k] = active_d && (32'(cur_sel_d) == k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rst_sync_q <= '0;
            inc_sync_q     <= '0;
            ena_sync_q     <= '0;
            sync_valid_q   <= '0;
            ena_armed_q    <= 1'b0;
            sel_cnt_q      <= '0;
            state_q        <= ST_IDLE;
            cur_sel_q      <= '0;
            hold_cnt_q     <= '0;
            active_q       <= 1'b0;
            proj_ena_q     <= '0;
        end else begin
            sel_rst_sync_q <= {sel_rst_sync_q[0], ctrl_sel_rst_n};
            inc_sync_q     <= {inc_sync_q[1:0], ctrl_sel_inc};
            ena_sync_q     <= {ena_sync_q[1:0], ctrl_ena};
            // Marks when s2 holds a real pin sample rather than its reset value.
            sync_valid_q   <= {sync_valid_q[0], 1'b1};
            ena_armed_q    <= ena_armed_d;
            sel_cnt_q      <= sel_cnt_d;
            state_q        <= state_d;
            cur_sel_q      <= cur_sel_d;
            hold_cnt_q     <= hold_cnt_d;
            active_q       <= active_d;
            proj_ena_q     <= proj_ena_d;
        end
    end

    // Glitch-free clock gate: the enable may only change while clk is low.
    always_latch begin
        if (!clk) begin
            clk_en_lat = active_q;
        end
    end

    assign gclk   = clk & clk_en_lat;
    assign iw_rst = (state_q == ST_RUN) & rst_n;

    always_comb begin
        proj_iw = '0;
        for (int unsigned k = 0; k < N_PROJ; k++) begin
            if (active_q && (32'(cur_sel_q) == k)) begin
                proj_iw[18*k +: 18] = {uio_in, ui_in, iw_rst, gclk};
            end
        end
    end

    always_comb begin
        sel_ow = '0;
        for (int unsigned k = 0; k < N_PROJ; k++) begin
            if (32'(cur_sel_q) == k) begin
                sel_ow = proj_ow[24*k +: 24];
            end
        end
        ow_mux = active_q ? sel_ow : 24'h0;
    end

`ifdef TT_MUX_OUT_REG_EN
    logic [23:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= ow_mux;
        end
    end

    assign {uio_oe, uio_out, uo_out} = out_q;
`else
    assign {uio_oe, uio_out, uo_out} = ow_mux;
`endif

    assign proj_ena = proj_ena_q;
    assign sel_addr = sel_cnt_q;
    assign active   = active_q;

endmodule
